// File: rtl/byte_addr_gen.sv
// Registered word-address + byte-select to byte-address converter with valid/stall handshake.
// Define BYTE_ADDR_GEN_ALIGNCHK_EN to enable the registered alignment-error output.
module byte_addr_gen #(
    parameter int unsigned ARCHBITSZ = 16
) (
    input  logic                                        clk_i,
    input  logic                                        rst_n_i,
    input  logic                                        valid_i,
    input  logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0]    addr_i,
    input  logic [ARCHBITSZ/8-1:0]                      sel_i,
    input  logic                                        stall_i,
    output logic                                        valid_o,
    output logic [ARCHBITSZ-1:0]                        addr_o,
    output logic [$clog2(ARCHBITSZ/8):0]                len_o,
    output logic                                        err_o
);

    localparam int unsigned SELBITSZ  = ARCHBITSZ / 8;
    localparam int unsigned OFFBITSZ  = $clog2(SELBITSZ);
    localparam int unsigned ADDRBITSZ = ARCHBITSZ - OFFBITSZ;

    logic [OFFBITSZ-1:0]  off;
    logic [OFFBITSZ:0]    len_d;
    logic [ARCHBITSZ-1:0] addr_d;

    logic                 valid_q;
    logic [ARCHBITSZ-1:0] addr_q;
    logic [OFFBITSZ:0]    len_q;

    // Descending scan so the lowest set lane is the last one written.
    always_comb begin
        off   = '0;
        len_d = '0;
        for (int i = int'(SELBITSZ) - 1; i >= 0; i--) begin
            if (sel_i[i]) off = OFFBITSZ'(i);
        end
        for (int i = 0; i < int'(SELBITSZ); i++) begin
            len_d = len_d + {{OFFBITSZ{1'b0}}, sel_i[i]};
        end
        addr_d = {addr_i[ADDRBITSZ-1:0], off};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
        end else if (!stall_i) begin
            valid_q <= valid_i;
            addr_q  <= addr_d;
            len_q   <= len_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign len_o   = len_q;

`ifdef BYTE_ADDR_GEN_ALIGNCHK_EN
    localparam logic [OFFBITSZ:0] LenOne = 1;
    localparam logic [SELBITSZ:0] SelOne = 1;

    logic [SELBITSZ:0] run_mask;
    logic [SELBITSZ:0] sel_shift;
    logic              err_d;
    logic              err_q;

    // A legal select is a single run of len_d lanes starting at off.
    always_comb begin
        run_mask  = (SelOne << len_d) - SelOne;
        sel_shift = {1'b0, sel_i >> off};
        err_d     = (len_d == '0)
                  || (sel_shift != run_mask)
                  || ((len_d & (len_d - LenOne)) != '0)
                  || (({1'b0, off} & (len_d - LenOne)) != '0);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else if (!stall_i) begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_byte_addr_gen.sv
// Scoreboard bench for byte_addr_gen (ARCHBITSZ=32): random and directed requests checked
// against an arithmetic reference model; a monitor pops expected responses as they emerge.
module tb_byte_addr_gen;

    typedef struct {
        logic [31:0] addr;
        int          len;
        bit          err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic [29:0] addr_i = '0;
    logic [3:0]  sel_i = '0;
    logic        stall_i = 1'b0;
    logic        valid_o;
    logic [31:0] addr_o;
    logic [2:0]  len_o;
    logic        err_o;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    logic        mon_st, mon_vi, mon_rst;
    logic        prev_valid;
    logic [31:0] prev_addr;
    logic [2:0]  prev_len;
    logic        prev_err;

    byte_addr_gen #(.ARCHBITSZ(32)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .valid_i (valid_i),
        .addr_i  (addr_i),
        .sel_i   (sel_i),
        .stall_i (stall_i),
        .valid_o (valid_o),
        .addr_o  (addr_o),
        .len_o   (len_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [29:0] a, input logic [3:0] s);
        exp_t e;
        int   off = 0, hi = -1, n = 0;
        bit   found = 0;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) begin
                n++;
                if (!found) begin off = i; found = 1; end
                hi = i;
            end
        end
        e.addr = 32'(a) * 32'd4 + 32'(off);
        e.len  = n;
`ifdef BYTE_ADDR_GEN_ALIGNCHK_EN
        e.err = !(n != 0 && (hi - off + 1) == n && (n == 1 || n == 2 || n == 4) && (off % n) == 0);
`else
        e.err = 0;
`endif
        return e;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic [29:0] a, input logic [3:0] s, input logic st);
        @(negedge clk);
        valid_i = v; addr_i = a; sel_i = s; stall_i = st;
        if (v && !st && rst_n) sb.push_back(model(a, s));
    endtask

    // Monitor: samples the handshake at the edge, inspects outputs 1 time unit later.
    always @(posedge clk) begin
        exp_t e;
        mon_st = stall_i; mon_vi = valid_i; mon_rst = rst_n;
        #1;
        if (mon_rst) begin
            if (!mon_st) begin
                check("valid_o", longint'(valid_o), longint'(mon_vi));
                if (valid_o) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("addr_o", longint'(addr_o), longint'(e.addr));
                        check("len_o", longint'(len_o), longint'(e.len));
                        check("err_o", longint'(err_o), longint'(e.err));
                    end
                end
            end else begin
                check("stall_valid", longint'(valid_o), longint'(prev_valid));
                check("stall_addr", longint'(addr_o), longint'(prev_addr));
                check("stall_len", longint'(len_o), longint'(prev_len));
                check("stall_err", longint'(err_o), longint'(prev_err));
            end
        end
        prev_valid = valid_o; prev_addr = addr_o; prev_len = len_o; prev_err = err_o;
    end

    initial begin
        exp_t e;
        #1;
        check("reset_valid", longint'(valid_o), 0);
        check("reset_addr", longint'(addr_o), 0);
        check("reset_len", longint'(len_o), 0);
        check("reset_err", longint'(err_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        drive(1, 30'h0000_0004, 4'b0100, 0);
        drive(1, 30'h3FFF_FFFF, 4'b1111, 0);
        drive(1, 30'h3FFF_FFFF, 4'b1000, 0);
        drive(1, 30'h0000_1234, 4'b0110, 0);
        drive(1, 30'h0000_1234, 4'b1100, 0);
        drive(1, 30'h0000_0055, 4'b0101, 0);
        drive(1, 30'h0000_0055, 4'b0000, 0);
        drive(0, 30'h0000_0077, 4'b0011, 0);

        // Stall: capture 0x10, then hold for 3 cycles with changing inputs
        drive(1, 30'h0000_0004, 4'b0001, 0);
        drive(1, 30'h0000_0100, 4'b1111, 1);
        drive(0, 30'h0000_0200, 4'b0010, 1);
        drive(1, 30'h0000_0300, 4'b0100, 1);
        drive(1, 30'h0000_0008, 4'b0011, 0);

        // Asynchronous reset between edges while valid_o is high
        drive(1, 30'h0000_0ABC, 4'b1000, 0);
        @(negedge clk);
        valid_i = 1'b0;
        check("pre_reset_valid", longint'(valid_o), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", longint'(valid_o), 0);
        check("async_addr", longint'(addr_o), 0);
        check("async_len", longint'(len_o), 0);
        check("async_err", longint'(err_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        valid_i = 1'b1; addr_i = 30'h0000_0321; sel_i = 4'b0010; stall_i = 1'b0;
        sb.push_back(model(30'h0000_0321, 4'b0010));

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(3) != 0), 30'($urandom), 4'($urandom),
                  ($urandom_range(3) == 0));
        end
        drive(0, '0, '0, 0);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", longint'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
